regfile_op_sequencer: RTL and testbench
=======================================

// Module: regfile_op_sequencer
// PURPOSE
//   Multi-cycle controller and execute stage wrapped around the 8-entry register file.
//   Takes one register-to-register instruction per handshake: Rd = Rn op shift(Rm).
//   Drives the register file's readnum/writenum/write/data_in.
//   Holds the A/B/C operand registers, shifter, ALU and Z/N/V status flags.
// PARAMETERS
//   DATA_W  16  datapath / register width
//   ADDR_W  3   register index width (2**ADDR_W registers)
// PORTS
//   clk         in   1       clock, all state updates on rising edge
//   rst_n       in   1       synchronous active-low reset
//   start       in   1       request; accepted when start & ready at a rising edge
//   ready       out  1       high only in IDLE
//   op          in   2       00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B; captured on accept
//   shift       in   2       on B: 00 none, 01 LSL1, 10 LSR1 (0 fill), 11 ASR1; captured on accept
//   rn, rm, rd  in   ADDR_W  source A, source B, destination; captured on accept
//   readnum     out  ADDR_W  register file read select
//   rf_rdata    in   DATA_W  register file read data, combinational in readnum
//   writenum    out  ADDR_W  register file write select
//   write       out  1       register file write enable
//   wdata       out  DATA_W  register file write data (= C)
//   done        out  1       one-cycle pulse, coincident with write
//   z, n, v     out  1 each  status: zero, negative (C[MSB]), signed overflow
// BEHAVIOUR
//   Reset: next edge with rst_n=0 forces IDLE.
//     A=B=C=0, z=n=v=0, readnum=writenum=0, write=0, done=0, ready=1.
//     Reset mid-operation abandons the instruction, with no write.
//   FSM: IDLE -> READ_A -> READ_B -> EXEC -> WRITE -> IDLE, one cycle per state.
//   IDLE:
//     - ready=1.
//     - On start: latch op/shift/rn/rm/rd and go to READ_A.
//     - Otherwise stay in IDLE.
//   READ_A: readnum=rn; A <= rf_rdata at end of cycle.
//   READ_B: readnum=rm; B <= rf_rdata at end of cycle.
//   EXEC:
//     - C <= ALU(A, shift(B)); result is modulo 2**DATA_W.
//     - z <= (result==0); n <= result[DATA_W-1].
//     - v <= signed overflow for ADD/SUB, else 0.
//     - Flags change only in EXEC.
//   WRITE:
//     - write=1, writenum=rd, wdata=C, done=1.
//     - The register file captures at the edge leaving WRITE.
//   Outputs outside the named states:
//     - readnum holds its last value.
//     - write=0, done=0.
//     - wdata always = C.
//   start while busy (not IDLE) is ignored, not queued.
//     Back-to-back throughput: one instruction per 5 cycles.
//   Latency: accept at edge k; write/done high during the cycle after edge k+3;
//     Rd updated at edge k+4.
//   Hazards:
//     - rd==rn or rd==rm: operands are read before the write, so old values are used.
//     - rn==rm: legal.
//   Shifter:
//     - ASR1 replicates the MSB.
//     - LSL1 drops the MSB.
//     - NOT B ignores A and sets v=0.
// TESTING (bench includes behavioural 8x16 register file model)
//   1. Reset, then R1=5, R2=3, ADD rd=R3, no shift
//      -> write pulse to R3=8, done 1 cycle, z=n=v=0, ready back next cycle.
//   2. R1=0x7FFF, R2=1, ADD rd=R4
//      -> R4=0x8000, n=1, v=1, z=0.
//   3. R1=4, R2=4, SUB rd=R1
//      -> R1=0, z=1; operand A read as 4 (hazard case).
//   4. R2=0x8002, NOT B with ASR1 rd=R5
//      -> shift(B)=0xC001, R5=0x3FFE, v=0; LSR1 variant -> R5=0xBFFE.
//   5. start held high for 12 cycles
//      -> exactly 3 accepts at 5-cycle spacing, no write while IDLE.
//   6. rst_n low during EXEC
//      -> next cycle IDLE, write never asserted, destination unchanged, flags 0.

Source files
------------

// File: rtl/regfile_op_sequencer.sv
// Purpose: multi-cycle controller plus execute stage for Rd = Rn op shift(Rm) on an external register file.
// Latency: accept at edge k, write/done high in the cycle after edge k+3, Rd updated at edge k+4.
// Backpressure: ready is high only in IDLE; start while busy is dropped, not queued.
module regfile_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic [1:0]        op,
  input  logic [1:0]        shift,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [ADDR_W-1:0] rd,
  output logic [ADDR_W-1:0] readnum,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] writenum,
  output logic              write,
  output logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              z,
  output logic              n,
  output logic              v
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ_A = 3'd1,
    READ_B = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [1:0]          shift_q;
  logic [ADDR_W-1:0]   rm_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   c_q;
  logic [DATA_W-1:0]   b_sh;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_v;

  assign ready = (state == IDLE);
  assign wdata = c_q;

  // Shifter on B followed by the ALU; overflow only meaningful for ADD/SUB.
  always_comb begin
    b_sh = b_q;
    case (shift_q)
      2'b01:   b_sh = {b_q[MSB-1:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[MSB:1]};
      2'b11:   b_sh = {b_q[MSB], b_q[MSB:1]};
      default: b_sh = b_q;
    endcase
    alu_res = '0;
    alu_v   = 1'b0;
    case (op_q)
      2'b00: begin
        alu_res = a_q + b_sh;
        alu_v   = (a_q[MSB] == b_sh[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      2'b01: begin
        alu_res = a_q - b_sh;
        alu_v   = (a_q[MSB] != b_sh[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      2'b10:   alu_res = a_q & b_sh;
      default: alu_res = ~b_sh;
    endcase
  end

  // Sequencer: readnum is set one state early so rf_rdata is valid in READ_A/READ_B.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= 2'b00;
      shift_q  <= 2'b00;
      rm_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      z        <= 1'b0;
      n        <= 1'b0;
      v        <= 1'b0;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            shift_q <= shift;
            rm_q    <= rm;
            rd_q    <= rd;
            readnum <= rn;
            state   <= READ_A;
          end
        end
        READ_A: begin
          a_q     <= rf_rdata;
          readnum <= rm_q;
          state   <= READ_B;
        end
        READ_B: begin
          b_q   <= rf_rdata;
          state <= EXEC;
        end
        EXEC: begin
          c_q      <= alu_res;
          z        <= (alu_res == '0);
          n        <= alu_res[MSB];
          v        <= alu_v;
          writenum <= rd_q;
          write    <= 1'b1;
          done     <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          write <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Purpose: bench for regfile_op_sequencer with an 8x16 register file and an instruction-level reference.
// Latency: reference completes each accepted instruction 4 edges after acceptance.
// Backpressure: reference accepts start only when no instruction is outstanding.
module tb_regfile_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready;
  logic [1:0]  op = 2'b00;
  logic [1:0]  shift = 2'b00;
  logic [2:0]  rn = '0;
  logic [2:0]  rm = '0;
  logic [2:0]  rd = '0;
  logic [2:0]  readnum;
  logic [15:0] rf_rdata;
  logic [2:0]  writenum;
  logic        write;
  logic [15:0] wdata;
  logic        done;
  logic        z, n, v;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  logic        pre_en = 1'b0;
  logic [2:0]  pre_idx = '0;
  logic [15:0] pre_val = '0;

  always #5 clk = ~clk;

  regfile_op_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .op(op), .shift(shift), .rn(rn), .rm(rm), .rd(rd),
    .readnum(readnum), .rf_rdata(rf_rdata), .writenum(writenum),
    .write(write), .wdata(wdata), .done(done), .z(z), .n(n), .v(v)
  );

  // Register file driven by the DUT, with a bench-side preload port.
  logic [15:0] rf [8];
  assign rf_rdata = rf[readnum];
  always @(posedge clk) begin
    if (write) rf[writenum] <= wdata;
    if (pre_en) rf[pre_idx] <= pre_val;
  end

  // Instruction result from plain integer arithmetic: returns {overflow, result}.
  function automatic logic [16:0] ref_exec(input logic [1:0] f_op, input logic [1:0] f_sh,
                                           input logic [15:0] a, input logic [15:0] b);
    int bi, sa, sb, r;
    logic [15:0] bs;
    logic ov;
    bi = int'(b);
    case (f_sh)
      2'd1: bi = (bi * 2) % 65536;
      2'd2: bi = bi / 2;
      2'd3: bi = bi / 2 + ((bi >= 32768) ? 32768 : 0);
      default: bi = int'(b);
    endcase
    bs = 16'(bi);
    sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
    sb = (bs >= 16'h8000) ? int'(bs) - 65536 : int'(bs);
    ov = 1'b0;
    case (f_op)
      2'd0: begin r = sa + sb; ov = (r > 32767) || (r < -32768); end
      2'd1: begin r = sa - sb; ov = (r > 32767) || (r < -32768); end
      2'd2: r = int'(a & bs);
      default: r = int'(~bs);
    endcase
    return {ov, 16'(r)};
  endfunction

  // Reference: m_cnt counts cycles left until the instruction retires (0 = idle).
  logic [15:0] m_reg [8];
  int          m_cnt = 0;
  logic [2:0]  m_rd, m_rm, m_readnum;
  logic [15:0] m_res, m_c;
  logic        m_pv, m_z, m_n, m_v;
  logic [16:0] m_tmp;

  always @(posedge clk) begin
    if (pre_en) m_reg[pre_idx] <= pre_val;
    if (m_cnt == 1) m_reg[m_rd] <= m_res;
    if (!rst_n) begin
      m_cnt <= 0;
      m_z <= 1'b0; m_n <= 1'b0; m_v <= 1'b0;
      m_c <= '0;
      m_readnum <= '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_tmp = ref_exec(op, shift, m_reg[rn], m_reg[rm]);
        m_res <= m_tmp[15:0];
        m_pv  <= m_tmp[16];
        m_rd  <= rd;
        m_rm  <= rm;
        m_readnum <= rn;
        m_cnt <= 4;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 4) m_readnum <= m_rm;
      if (m_cnt == 2) begin
        m_c <= m_res;
        m_z <= (m_res == 16'h0000);
        m_n <= m_res[15];
        m_v <= m_pv;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs and register file against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, m_cnt == 0);
      chk("write", write, m_cnt == 1);
      chk("done", done, m_cnt == 1);
      chk("readnum", readnum, m_readnum);
      chk("wdata", wdata, m_c == 16'h0 && m_cnt == 1 ? m_res : (m_cnt == 1 ? m_res : m_c));
      chk("z", z, m_z);
      chk("n", n, m_n);
      chk("v", v, m_v);
      if (m_cnt == 1) chk("writenum", writenum, m_rd);
      for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), rf[i], m_reg[i]);
    end
  end

  task automatic preload(input logic [2:0] i, input logic [15:0] d);
    @(negedge clk); pre_en = 1'b1; pre_idx = i; pre_val = d;
    @(negedge clk); pre_en = 1'b0;
  endtask

  // Issues one instruction and returns in the negedge of its WRITE cycle.
  task automatic issue(input logic [1:0] o, input logic [1:0] s,
                       input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
    @(negedge clk); start = 1'b1; op = o; shift = s; rn = a; rm = b; rd = d;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n_done, first, last;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_write", write, 0);
    chk("rst_done", done, 0);
    chk("rst_readnum", readnum, 0);
    chk("rst_writenum", writenum, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_flags", {z, n, v}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);
    chk_en = 1'b1;

    // 1: 5 + 3 -> R3
    preload(3'd1, 16'd5); preload(3'd2, 16'd3);
    issue(2'b00, 2'b00, 3'd1, 3'd2, 3'd3);
    chk("t1_write", {write, done}, 2'b11);
    chk("t1_writenum", writenum, 3);
    chk("t1_wdata", wdata, 16'd8);
    chk("t1_flags", {z, n, v}, 3'b000);
    @(negedge clk);
    chk("t1_ready", ready, 1);
    chk("t1_done_off", done, 0);
    chk("t1_r3", rf[3], 16'd8);

    // 2: 0x7FFF + 1 overflows
    preload(3'd1, 16'h7FFF); preload(3'd2, 16'h0001);
    issue(2'b00, 2'b00, 3'd1, 3'd2, 3'd4);
    chk("t2_wdata", wdata, 16'h8000);
    chk("t2_flags", {z, n, v}, 3'b011);
    @(negedge clk);
    chk("t2_r4", rf[4], 16'h8000);

    // 3: 4 - 4 into R1, R1 is also a source
    preload(3'd1, 16'd4); preload(3'd2, 16'd4);
    issue(2'b01, 2'b00, 3'd1, 3'd2, 3'd1);
    chk("t3_wdata", wdata, 16'h0000);
    chk("t3_flags", {z, n, v}, 3'b100);
    @(negedge clk);
    chk("t3_r1", rf[1], 16'h0000);

    // 4: NOT of shifted 0x8002
    preload(3'd2, 16'h8002);
    issue(2'b11, 2'b11, 3'd1, 3'd2, 3'd5);
    chk("t4_asr_wdata", wdata, 16'h3FFE);
    chk("t4_asr_v", v, 0);
    @(negedge clk);
    issue(2'b11, 2'b10, 3'd1, 3'd2, 3'd5);
    chk("t4_lsr_wdata", wdata, 16'hBFFE);
    chk("t4_lsr_n", n, 1);
    @(negedge clk);
    chk("t4_r5", rf[5], 16'hBFFE);

    // 5: start held for 12 cycles
    @(negedge clk); start = 1'b1; op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd6;
    n_done = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 11) start = 1'b0;
      if (done) begin
        n_done++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("t5_accepts", n_done, 3);
    chk("t5_first_done", first, 3);
    chk("t5_spacing", last - first, 10);

    // 6: reset while in EXEC
    preload(3'd1, 16'd4); preload(3'd2, 16'd4); preload(3'd7, 16'h1234);
    issue(2'b01, 2'b00, 3'd1, 3'd2, 3'd0);
    @(negedge clk);
    @(negedge clk); start = 1'b1; op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_z_before", z, 1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("t6_ready", ready, 1);
    chk("t6_write", write, 0);
    chk("t6_flags", {z, n, v}, 3'b000);
    repeat (3) @(negedge clk);
    chk("t6_r7", rf[7], 16'h1234);

    // Randomized traffic, including starts while busy and one reset pulse
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom_range(0, 65535)));
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      op    = 2'($urandom_range(0, 3));
      shift = 2'($urandom_range(0, 3));
      rn    = 3'($urandom_range(0, 7));
      rm    = 3'($urandom_range(0, 7));
      rd    = 3'($urandom_range(0, 7));
      rst_n = (i != 300);
    end
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
